// File: rtl/pmi_arbiter.sv
// rtl/pmi_arbiter.sv - I/D arbiter for the single pmi port; PMI_ARB_RR_EN selects round-robin tie-break
module pmi_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_err,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mfc
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  // Last timer value of a transaction; the abort fires when the timer sits here without mfc.
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          pick_d, pick_i;
`ifdef PMI_ARB_RR_EN
  // 1 when the D port received the most recent grant.
  logic          last_d_q, last_d_d;
`endif

  // Grant selection: D wins unless round-robin hands a tie to the port not served last.
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
`ifdef PMI_ARB_RR_EN
    if (d_req && i_req) pick_d = !last_d_q;
    else                pick_d = d_req;
`else
    pick_d = d_req;
`endif
    pick_i = i_req && !pick_d;
  end

  // Next-state and registered outputs of the IDLE/BUSY_I/BUSY_D controller.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef PMI_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = BUSY_D;
          timer_d     = '0;
          mem_rd_d    = !d_wr;
          mem_wr_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wr ? d_wdata : '0;
`ifdef PMI_ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (pick_i) begin
          state_d     = BUSY_I;
          timer_d     = '0;
          mem_rd_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
`ifdef PMI_ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (mfc) begin
          // Completion wins over a timeout landing in the same cycle.
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            // Stores leave the last load data visible.
            if (mem_rd_q) d_rdata_d = mem_rdata;
          end
        end else if (timer_q == TMAX) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (state_q == BUSY_I) i_err_d = 1'b1;
          else                   d_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef PMI_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef PMI_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_pmi_arbiter.sv
// tb/tb_pmi_arbiter.sv - scoreboard bench for pmi_arbiter with a responding memory model
module tb_pmi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_wr = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mfc = 1'b0;

  pmi_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mfc(mfc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port_d;
    logic        err;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_resp_cyc = 0;
  logic [31:0] exp_d_rdata = '0;
  bit   mem_auto = 1'b1;
  bit   mfc_force = 1'b0;
  int   mfc_delay = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h100) return 32'h00A00093;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void push_exp(input logic port_d, input logic err, input logic wr,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.port_d = port_d; e.err = err; e.wr = wr; e.addr = addr; e.wdata = wdata;
    if (port_d && wr) e.rdata = exp_d_rdata;
    else              e.rdata = mdata(addr);
    if (port_d && !wr && !err) exp_d_rdata = e.rdata;
    sb.push_back(e);
  endfunction

  // Memory model: checks each new command against the head of the scoreboard and answers with mfc.
  initial begin
    int wait_cnt = 0;
    bit responded = 1'b0;
    logic [31:0] cmd_addr = '0;
    forever begin
      @(negedge clk);
      mfc = mfc_force;
      if (mem_rd || mem_wr) begin
        if (!responded) begin
          wait_cnt++;
          if (wait_cnt == 1) begin
            cmd_addr = mem_addr;
            if (sb.size() > 0) begin
              check("cmd_rd", mem_rd, !sb[0].wr);
              check("cmd_wr", mem_wr, sb[0].wr);
              check("cmd_addr", mem_addr, sb[0].addr);
              if (sb[0].wr) check("cmd_wdata", mem_wdata, sb[0].wdata);
            end
          end else begin
            check("cmd_stable", mem_addr, cmd_addr);
          end
          if (mem_auto && wait_cnt == mfc_delay + 1) begin
            mfc = 1'b1;
            mem_rdata = mdata(mem_addr);
            responded = 1'b1;
          end
        end
      end else begin
        wait_cnt = 0;
        responded = 1'b0;
      end
      if (mem_rd && mem_wr) check("rd_wr_excl", {mem_rd, mem_wr}, 2'b10);
    end
  end

  // Response monitor: every ack/err pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_ack || i_err || d_ack || d_err) begin
        last_resp_cyc = cyc;
        if (sb.size() == 0) begin
          check("spurious_resp", {i_ack, i_err, d_ack, d_err}, 4'b0000);
        end else begin
          e = sb.pop_front();
          check("resp_kind", {i_ack, i_err, d_ack, d_err},
                e.port_d ? (e.err ? 4'b0001 : 4'b0010) : (e.err ? 4'b0100 : 4'b1000));
          if (!e.err) check(e.port_d ? "d_rdata" : "i_rdata", e.port_d ? d_rdata : i_rdata, e.rdata);
          done_cnt++;
        end
      end
    end
  end

  task automatic wait_done(input int n, input int budget);
    int target;
    target = done_cnt + n;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) break;
    end
    check("done_in_time", done_cnt >= target, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    int c0;
    int base;
    // Reset state
    idle_cycles(3);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_acks", {i_ack, i_err, d_ack, d_err}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // 1: fetch only, 3-cycle latency
    mfc_delay = 1;
    push_exp(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    i_addr = 32'h100; i_req = 1'b1; c0 = cyc;
    wait_done(1, 20);
    i_req = 1'b0;
    check("t1_latency", last_resp_cyc - c0, 3);
    idle_cycles(2);
    check("t1_rdata_hold", i_rdata, 32'h00A00093);

    // 3: both requests held for four transactions
    d_addr = 32'h3000; d_wr = 1'b0; i_addr = 32'h400;
`ifdef PMI_ARB_RR_EN
    push_exp(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0);
    push_exp(1'b0, 1'b0, 1'b0, 32'h400, 32'h0);
    push_exp(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0);
    push_exp(1'b0, 1'b0, 1'b0, 32'h400, 32'h0);
`else
    for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0);
`endif
    i_req = 1'b1; d_req = 1'b1;
    wait_done(4, 80);
    i_req = 1'b0; d_req = 1'b0;
    idle_cycles(3);
    check("t3_sb_drained", sb.size(), 0);

    // 2: store leaves d_rdata untouched
    mfc_delay = 2;
    push_exp(1'b1, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF);
    d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wr = 1'b1; d_req = 1'b1;
    wait_done(1, 20);
    d_req = 1'b0; d_wr = 1'b0;
    idle_cycles(2);
    check("t2_d_rdata_kept", d_rdata, exp_d_rdata);

    // 4: no mfc -> timeout error after 8 busy cycles, late mfc ignored
    mem_auto = 1'b0;
    push_exp(1'b1, 1'b1, 1'b0, 32'h2400, 32'h0);
    d_addr = 32'h2400; d_req = 1'b1; c0 = cyc;
    wait_done(1, 30);
    d_req = 1'b0;
    check("t4_err_cycle", last_resp_cyc - c0, 9);
    check("t4_cmd_dropped", {mem_rd, mem_wr}, 0);
    base = done_cnt;
    mfc_force = 1'b1; idle_cycles(1); mfc_force = 1'b0;
    idle_cycles(4);
    check("t4_late_mfc", done_cnt, base);
    mem_auto = 1'b1;

    // 5: reset during BUSY_I, then a fresh fetch
    mfc_delay = 5;
    i_addr = 32'h600; i_req = 1'b1;
    idle_cycles(2);
    rst_n = 1'b0; i_req = 1'b0;
    @(negedge clk);
    check("t5_mem_rd_cleared", mem_rd, 0);
    #1 rst_n = 1'b1;
    exp_d_rdata = '0;
    base = done_cnt;
    idle_cycles(8);
    check("t5_no_ack", done_cnt, base);
    mfc_delay = 1;
    push_exp(1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
    i_addr = 32'h500; i_req = 1'b1;
    wait_done(1, 20);
    i_req = 1'b0;

    // 6: stray mfc in IDLE, then a fetch whose request drops mid-busy
    idle_cycles(2);
    base = done_cnt;
    mfc_force = 1'b1; idle_cycles(1); mfc_force = 1'b0;
    idle_cycles(3);
    check("t6_stray_mfc", done_cnt, base);
    mfc_delay = 4;
    push_exp(1'b0, 1'b0, 1'b0, 32'h700, 32'h0);
    i_addr = 32'h700; i_req = 1'b1;
    idle_cycles(2);
    i_req = 1'b0;
    wait_done(1, 20);
    idle_cycles(6);
    check("t6_single_ack", done_cnt, base + 1);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
